// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: ROB/RS sizing,
// ALU operation and opcode encodings, the entry record and the CDB tag match.
package alu_rs_pkg;

  localparam int ROB_SIZE_bits      = 4;
  localparam int BUFFER_SIZE_bitsRS = 4;
  localparam int RS_DEPTH           = 1 << BUFFER_SIZE_bitsRS;

  // ALU operation encodings
  localparam logic [3:0] ALUOP_ADD  = 4'b0000;
  localparam logic [3:0] ALUOP_SUB  = 4'b0001;
  localparam logic [3:0] ALUOP_AND  = 4'b0010;
  localparam logic [3:0] ALUOP_OR   = 4'b0011;
  localparam logic [3:0] ALUOP_XOR  = 4'b0100;
  localparam logic [3:0] ALUOP_SLL  = 4'b0101;
  localparam logic [3:0] ALUOP_SRL  = 4'b0110;
  localparam logic [3:0] ALUOP_SRA  = 4'b0111;
  localparam logic [3:0] ALUOP_SLT  = 4'b1000;
  localparam logic [3:0] ALUOP_SLTU = 4'b1001;

  // Opcodes carried through to the ALU
  localparam logic [11:0] OPC_RTYPE  = 12'h033;
  localparam logic [11:0] OPC_ITYPE  = 12'h013;
  localparam logic [11:0] OPC_BRANCH = 12'h063;
  localparam logic [11:0] OPC_LUI    = 12'h037;

  // One reservation entry; a tag of 0 means the operand value is present
  typedef struct packed {
    logic                   busy;
    logic [ROB_SIZE_bits:0] roben;
    logic [11:0]            opcode;
    logic [3:0]             aluop;
    logic                   is_beq;
    logic                   is_bne;
    logic [31:0]            vj;
    logic [ROB_SIZE_bits:0] qj;
    logic [31:0]            vk;
    logic [ROB_SIZE_bits:0] qk;
  } rs_entry_t;

  // True when a broadcast result satisfies an outstanding (nonzero) tag
  function automatic logic cdb_hits(input logic                   tag,
                                    input logic [ROB_SIZE_bits:0] wait_tag,
                                    input logic [ROB_SIZE_bits:0] cdb_tag);
    return tag && (wait_tag != '0) && (wait_tag == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder shared by the free-slot and ready-entry searches.
module rs_select #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  // Scan from the top down so the lowest requesting index is the last writer
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      o_idx = i_req[i] ? IW'(i) : o_idx;
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: allocates into the lowest free slot, snoops the CDB
// for outstanding operands and issues the lowest ready slot to the ALU each cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [ROB_SIZE_bits:0]        alloc_ROBEN,
  input  logic [11:0]                   alloc_opcode,
  input  logic [3:0]                    alloc_ALUOP,
  input  logic                          alloc_is_beq,
  input  logic                          alloc_is_bne,
  input  logic [31:0]                   alloc_Vj,
  input  logic [ROB_SIZE_bits:0]        alloc_Qj,
  input  logic [31:0]                   alloc_Vk,
  input  logic [ROB_SIZE_bits:0]        alloc_Qk,
  input  logic                          cdb_valid,
  input  logic [ROB_SIZE_bits:0]        cdb_ROBEN,
  input  logic [31:0]                   cdb_res,
  input  logic                          flush,
  output logic [ROB_SIZE_bits:0]        ROBEN,
  output logic [11:0]                   opcode,
  output logic [3:0]                    ALUOP,
  output logic                          is_beq,
  output logic                          is_bne,
  output logic [31:0]                   A,
  output logic [31:0]                   B,
  output logic [BUFFER_SIZE_bitsRS:0]   count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = BUFFER_SIZE_bitsRS + 1;

  rs_entry_t         r_entry [DEPTH];
  logic [DEPTH-1:0]  w_free;
  logic [DEPTH-1:0]  w_ready;
  logic              w_any_free;
  logic              w_any_ready;
  logic [IW-1:0]     w_free_idx;
  logic [IW-1:0]     w_ready_idx;
  logic              w_alloc;
  logic              w_issue;
  rs_entry_t         w_new_entry;
  rs_entry_t         w_issue_entry;
  logic [CW-1:0]     w_count_next;

  // Classify each slot; readiness uses registered tags so a wake-up counts next edge
  always_comb begin
    w_free  = '0;
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_free[i]  = ~r_entry[i].busy;
      w_ready[i] = r_entry[i].busy && (r_entry[i].qj == '0) && (r_entry[i].qk == '0);
    end
  end

  rs_select #(.N(DEPTH), .IW(IW)) u_free_sel (
    .i_req   (w_free),
    .o_valid (w_any_free),
    .o_idx   (w_free_idx)
  );

  rs_select #(.N(DEPTH), .IW(IW)) u_ready_sel (
    .i_req   (w_ready),
    .o_valid (w_any_ready),
    .o_idx   (w_ready_idx)
  );

  // Held low in reset so every output reads 0 while rst is asserted
  assign alloc_ready   = rst & w_any_free & ~flush;
  assign w_alloc       = alloc_valid & alloc_ready;
  assign w_issue       = w_any_ready & ~flush;
  assign w_issue_entry = r_entry[w_ready_idx];

  // Build the incoming entry, bypassing a result broadcast in the same cycle
  always_comb begin
    w_new_entry        = '0;
    w_new_entry.busy   = 1'b1;
    w_new_entry.roben  = alloc_ROBEN;
    w_new_entry.opcode = alloc_opcode;
    w_new_entry.aluop  = alloc_ALUOP;
    w_new_entry.is_beq = alloc_is_beq;
    w_new_entry.is_bne = alloc_is_bne;
    if (cdb_hits(cdb_valid, alloc_Qj, cdb_ROBEN)) begin
      w_new_entry.vj = cdb_res;
      w_new_entry.qj = '0;
    end else begin
      w_new_entry.vj = alloc_Vj;
      w_new_entry.qj = alloc_Qj;
    end
    if (cdb_hits(cdb_valid, alloc_Qk, cdb_ROBEN)) begin
      w_new_entry.vk = cdb_res;
      w_new_entry.qk = '0;
    end else begin
      w_new_entry.vk = alloc_Vk;
      w_new_entry.qk = alloc_Qk;
    end
  end

  // Occupancy moves by +1 per allocation and -1 per issue
  always_comb begin
    case ({w_alloc, w_issue})
      2'b10:   w_count_next = count + CW'(1);
      2'b01:   w_count_next = count - CW'(1);
      default: w_count_next = count;
    endcase
  end

  // Entry storage: free on issue, load on allocation, otherwise snoop the CDB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i].busy <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_issue && (IW'(i) == w_ready_idx)) begin
          r_entry[i].busy <= 1'b0;
        end else if (w_alloc && (IW'(i) == w_free_idx)) begin
          r_entry[i] <= w_new_entry;
        end else if (r_entry[i].busy) begin
          if (cdb_hits(cdb_valid, r_entry[i].qj, cdb_ROBEN)) begin
            r_entry[i].vj <= cdb_res;
            r_entry[i].qj <= '0;
          end
          if (cdb_hits(cdb_valid, r_entry[i].qk, cdb_ROBEN)) begin
            r_entry[i].vk <= cdb_res;
            r_entry[i].qk <= '0;
          end
        end
      end
    end
  end

  // Registered ALU-facing outputs; a zero ROBEN marks a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ROBEN  <= '0;
      opcode <= 12'h000;
      ALUOP  <= 4'b0000;
      is_beq <= 1'b0;
      is_bne <= 1'b0;
      A      <= 32'h0;
      B      <= 32'h0;
    end else if (w_issue) begin
      ROBEN  <= w_issue_entry.roben;
      opcode <= w_issue_entry.opcode;
      ALUOP  <= w_issue_entry.aluop;
      is_beq <= w_issue_entry.is_beq;
      is_bne <= w_issue_entry.is_bne;
      A      <= w_issue_entry.vj;
      B      <= w_issue_entry.vk;
    end else begin
      ROBEN  <= '0;
      opcode <= 12'h000;
      ALUOP  <= 4'b0000;
      is_beq <= 1'b0;
      is_bne <= 1'b0;
      A      <= 32'h0;
      B      <= 32'h0;
    end
  end

  // Occupancy counter, cleared by a flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus a randomized run
// against a slot-array reference model of the reservation station rules.
`timescale 1ns/1ps
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int TW = ROB_SIZE_bits + 1;
  localparam int CW = BUFFER_SIZE_bitsRS + 1;
  localparam int D  = RS_DEPTH;

  logic clk = 1'b0;
  logic rst;
  logic alloc_valid, alloc_ready;
  logic [TW-1:0] alloc_ROBEN, alloc_Qj, alloc_Qk;
  logic [11:0] alloc_opcode;
  logic [3:0] alloc_ALUOP;
  logic alloc_is_beq, alloc_is_bne;
  logic [31:0] alloc_Vj, alloc_Vk;
  logic cdb_valid;
  logic [TW-1:0] cdb_ROBEN;
  logic [31:0] cdb_res;
  logic flush;
  logic [TW-1:0] ROBEN;
  logic [11:0] opcode;
  logic [3:0] ALUOP;
  logic is_beq, is_bne;
  logic [31:0] A, B;
  logic [CW-1:0] count;

  alu_rs #(.DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_ROBEN(alloc_ROBEN), .alloc_opcode(alloc_opcode), .alloc_ALUOP(alloc_ALUOP),
    .alloc_is_beq(alloc_is_beq), .alloc_is_bne(alloc_is_bne),
    .alloc_Vj(alloc_Vj), .alloc_Qj(alloc_Qj), .alloc_Vk(alloc_Vk), .alloc_Qk(alloc_Qk),
    .cdb_valid(cdb_valid), .cdb_ROBEN(cdb_ROBEN), .cdb_res(cdb_res),
    .flush(flush),
    .ROBEN(ROBEN), .opcode(opcode), .ALUOP(ALUOP), .is_beq(is_beq), .is_bne(is_bne),
    .A(A), .B(B), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per slot, order by slot index
  typedef struct {
    bit v;
    logic [TW-1:0] roben, qj, qk;
    logic [11:0] opc;
    logic [3:0] aluop;
    bit beq, bne;
    logic [31:0] vj, vk;
  } slot_t;

  slot_t m [D];
  int m_count;
  bit e_bubble;
  logic [TW-1:0] e_roben;
  logic [11:0] e_opc;
  logic [3:0] e_aluop;
  bit e_beq, e_bne;
  logic [31:0] e_a, e_b;

  task automatic model_reset();
    for (int i = 0; i < D; i++) m[i].v = 1'b0;
    m_count = 0;
    e_bubble = 1'b1; e_roben = '0; e_opc = '0; e_aluop = '0;
    e_beq = 1'b0; e_bne = 1'b0; e_a = '0; e_b = '0;
  endtask

  function automatic bit m_alloc_ready();
    bit any_free = 1'b0;
    for (int i = 0; i < D; i++) if (!m[i].v) any_free = 1'b1;
    return rst && any_free && !flush;
  endfunction

  // Apply the rules of one clock edge to the model using the current inputs
  task automatic model_step();
    int iss = -1;
    int fr = -1;
    bit do_alloc;
    if (flush) begin
      for (int i = 0; i < D; i++) m[i].v = 1'b0;
      m_count = 0;
      e_bubble = 1'b1; e_roben = '0; e_opc = '0; e_beq = 1'b0; e_bne = 1'b0;
      return;
    end
    do_alloc = alloc_valid && m_alloc_ready();
    for (int i = D - 1; i >= 0; i--) begin
      if (m[i].v && m[i].qj == 0 && m[i].qk == 0) iss = i;
      if (!m[i].v) fr = i;
    end
    if (iss >= 0) begin
      e_bubble = 1'b0; e_roben = m[iss].roben; e_opc = m[iss].opc; e_aluop = m[iss].aluop;
      e_beq = m[iss].beq; e_bne = m[iss].bne; e_a = m[iss].vj; e_b = m[iss].vk;
      m[iss].v = 1'b0;
      m_count--;
    end else begin
      e_bubble = 1'b1; e_roben = '0; e_opc = '0; e_beq = 1'b0; e_bne = 1'b0;
    end
    if (cdb_valid && cdb_ROBEN != 0) begin
      for (int i = 0; i < D; i++) begin
        if (m[i].v && m[i].qj == cdb_ROBEN) begin m[i].vj = cdb_res; m[i].qj = '0; end
        if (m[i].v && m[i].qk == cdb_ROBEN) begin m[i].vk = cdb_res; m[i].qk = '0; end
      end
    end
    if (do_alloc) begin
      m[fr].v = 1'b1; m[fr].roben = alloc_ROBEN; m[fr].opc = alloc_opcode;
      m[fr].aluop = alloc_ALUOP; m[fr].beq = alloc_is_beq; m[fr].bne = alloc_is_bne;
      m[fr].vj = alloc_Vj; m[fr].qj = alloc_Qj; m[fr].vk = alloc_Vk; m[fr].qk = alloc_Qk;
      if (cdb_valid && alloc_Qj != 0 && alloc_Qj == cdb_ROBEN) begin m[fr].vj = cdb_res; m[fr].qj = '0; end
      if (cdb_valid && alloc_Qk != 0 && alloc_Qk == cdb_ROBEN) begin m[fr].vk = cdb_res; m[fr].qk = '0; end
      m_count++;
    end
  endtask

  // Advance one clock: model follows the edge, then wait to the next negedge
  task automatic cyc();
    if (rst) model_step(); else model_reset();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_alloc(input bit v, input int rob, input logic [3:0] op,
                           input logic [31:0] vj, input int qj,
                           input logic [31:0] vk, input int qk);
    alloc_valid = v; alloc_ROBEN = TW'(rob); alloc_opcode = OPC_RTYPE; alloc_ALUOP = op;
    alloc_is_beq = 1'b0; alloc_is_bne = 1'b0;
    alloc_Vj = vj; alloc_Qj = TW'(qj); alloc_Vk = vk; alloc_Qk = TW'(qk);
  endtask

  task automatic set_cdb(input bit v, input int tag, input logic [31:0] res);
    cdb_valid = v; cdb_ROBEN = TW'(tag); cdb_res = res;
  endtask

  task automatic idle();
    set_alloc(1'b0, 0, 4'b0000, 32'h0, 0, 32'h0, 0);
    set_cdb(1'b0, 0, 32'h0);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    model_reset();
    #1;
    checks++; if (ROBEN !== '0) begin errors++; $display("FAIL reset_roben: got %0h expected 0", ROBEN); end
    checks++; if ({A, B} !== 64'h0) begin errors++; $display("FAIL reset_ab: got %0h/%0h expected 0/0", A, B); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL reset_alloc_ready: got %0b expected 0", alloc_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL release_alloc_ready: got %0b expected 1", alloc_ready); end
  endtask

  task automatic test_ready_issue();
    set_alloc(1'b1, 3, ALUOP_ADD, 32'd5, 0, 32'd7, 0);
    cyc();
    idle();
    checks++; if (ROBEN !== '0) begin errors++; $display("FAIL ready_no_same_edge: got %0h expected 0", ROBEN); end
    cyc();
    checks++; if (ROBEN !== TW'(3)) begin errors++; $display("FAIL ready_roben: got %0h expected 3", ROBEN); end
    checks++; if (A !== 32'd5 || B !== 32'd7) begin errors++; $display("FAIL ready_ab: got %0h/%0h expected 5/7", A, B); end
    checks++; if (ALUOP !== ALUOP_ADD || A + B !== 32'd12) begin errors++; $display("FAIL ready_alu_sum: got %0d expected 12", A + B); end
    checks++; if (count !== '0) begin errors++; $display("FAIL ready_count: got %0d expected 0", count); end
  endtask

  task automatic test_wakeup();
    set_alloc(1'b1, 7, ALUOP_SUB, 32'hDEAD, 4, 32'd1, 0);
    cyc();
    idle();
    cyc();
    checks++; if (ROBEN !== '0) begin errors++; $display("FAIL wake_wait: got %0h expected 0", ROBEN); end
    set_cdb(1'b1, 4, 32'h10);
    cyc();
    idle();
    checks++; if (ROBEN !== '0) begin errors++; $display("FAIL wake_not_same_edge: got %0h expected 0", ROBEN); end
    cyc();
    checks++; if (ROBEN !== TW'(7) || A !== 32'h10) begin errors++; $display("FAIL wake_issue: got rob %0h A %0h expected rob 7 A 10", ROBEN, A); end
  endtask

  task automatic test_bypass();
    set_alloc(1'b1, 9, ALUOP_AND, 32'd2, 0, 32'hFFFF, 6);
    set_cdb(1'b1, 6, 32'd9);
    cyc();
    idle();
    checks++; if (ROBEN !== '0) begin errors++; $display("FAIL bypass_wait: got %0h expected 0", ROBEN); end
    cyc();
    checks++; if (ROBEN !== TW'(9) || B !== 32'd9 || A !== 32'd2) begin errors++; $display("FAIL bypass_issue: got rob %0h B %0h expected rob 9 B 9", ROBEN, B); end
  endtask

  task automatic test_full();
    for (int i = 0; i < D; i++) begin
      set_alloc(1'b1, i + 1, ALUOP_OR, 32'h0, (i == 5) ? 21 : 20, i, 0);
      cyc();
    end
    idle();
    #1;
    checks++; if (count !== CW'(D)) begin errors++; $display("FAIL full_count: got %0d expected %0d", count, D); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready: got %0b expected 0", alloc_ready); end
    set_cdb(1'b1, 21, 32'hAB);
    cyc();
    idle();
    checks++; if (ROBEN !== '0 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_wake_edge: got rob %0h ready %0b expected 0/0", ROBEN, alloc_ready); end
    cyc();
    checks++; if (ROBEN !== TW'(6) || A !== 32'hAB || B !== 32'd5) begin errors++; $display("FAIL full_issue: got rob %0h A %0h B %0h expected 6/ab/5", ROBEN, A, B); end
    checks++; if (alloc_ready !== 1'b1 || count !== CW'(D - 1)) begin errors++; $display("FAIL full_freed: got ready %0b count %0d expected 1/%0d", alloc_ready, count, D - 1); end
    set_alloc(1'b1, 25, ALUOP_XOR, 32'h3, 0, 32'h5, 0);
    cyc();
    idle();
    checks++; if (count !== CW'(D)) begin errors++; $display("FAIL full_realloc_count: got %0d expected %0d", count, D); end
    cyc();
    checks++; if (ROBEN !== TW'(25) || A !== 32'h3) begin errors++; $display("FAIL full_realloc_issue: got %0h expected 19", ROBEN); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    cyc();
    idle();
    checks++; if (count !== '0) begin errors++; $display("FAIL flush_clear: got %0d expected 0", count); end
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, i + 1, ALUOP_ADD, 32'h0, 12, 32'h0, 0);
      cyc();
    end
    idle();
    checks++; if (count !== CW'(5)) begin errors++; $display("FAIL flush_fill5: got %0d expected 5", count); end
    set_alloc(1'b1, 9, ALUOP_ADD, 32'h1, 0, 32'h1, 0);
    set_cdb(1'b1, 12, 32'h44);
    flush = 1'b1;
    #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL flush_alloc_ready: got %0b expected 0", alloc_ready); end
    cyc();
    idle();
    checks++; if (count !== '0 || ROBEN !== '0) begin errors++; $display("FAIL flush_edge: got count %0d rob %0h expected 0/0", count, ROBEN); end
    set_cdb(1'b1, 12, 32'h44);
    cyc();
    idle();
    checks++; if (ROBEN !== '0) begin errors++; $display("FAIL flush_cdb_after1: got %0h expected 0", ROBEN); end
    cyc();
    checks++; if (ROBEN !== '0 || count !== '0) begin errors++; $display("FAIL flush_cdb_after2: got rob %0h count %0d expected 0/0", ROBEN, count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, i + 1, ALUOP_ADD, 32'h0, 13, 32'h0, 0);
      cyc();
    end
    set_alloc(1'b1, 15, ALUOP_ADD, 32'h55, 0, 32'h66, 0);
    cyc();
    idle();
    cyc();
    checks++; if (ROBEN !== TW'(15)) begin errors++; $display("FAIL rstmid_setup: got %0h expected f", ROBEN); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (ROBEN !== '0 || A !== '0 || B !== '0 || opcode !== '0) begin errors++; $display("FAIL rstmid_outputs: got rob %0h A %0h B %0h expected 0", ROBEN, A, B); end
    checks++; if (count !== '0 || alloc_ready !== 1'b0) begin errors++; $display("FAIL rstmid_count: got %0d ready %0b expected 0/0", count, alloc_ready); end
    cyc();
    cyc();
    rst = 1'b1;
    set_alloc(1'b1, 11, ALUOP_ADD, 32'd3, 0, 32'd4, 0);
    set_cdb(1'b1, 13, 32'h77);
    cyc();
    idle();
    checks++; if (ROBEN !== '0 || count !== CW'(1)) begin errors++; $display("FAIL rstmid_first_alloc: got rob %0h count %0d expected 0/1", ROBEN, count); end
    cyc();
    checks++; if (ROBEN !== TW'(11) || A !== 32'd3) begin errors++; $display("FAIL rstmid_issue: got %0h expected b", ROBEN); end
    cyc();
    checks++; if (ROBEN !== '0 || count !== '0) begin errors++; $display("FAIL rstmid_no_stale: got rob %0h count %0d expected 0/0", ROBEN, count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      alloc_valid  = ($urandom_range(0, 9) < 7);
      alloc_ROBEN  = TW'($urandom_range(1, 31));
      alloc_opcode = 12'($urandom);
      alloc_ALUOP  = 4'($urandom_range(0, 9));
      alloc_is_beq = 1'($urandom);
      alloc_is_bne = 1'($urandom);
      alloc_Vj     = $urandom;
      alloc_Vk     = $urandom;
      alloc_Qj     = ($urandom_range(0, 2) == 0) ? TW'(0) : TW'($urandom_range(1, 6));
      alloc_Qk     = ($urandom_range(0, 2) == 0) ? TW'(0) : TW'($urandom_range(1, 6));
      cdb_valid    = ($urandom_range(0, 2) != 0);
      cdb_ROBEN    = TW'($urandom_range(0, 8));
      cdb_res      = $urandom;
      flush        = ($urandom_range(0, 59) == 0);
      #1;
      checks++; if (alloc_ready !== m_alloc_ready()) begin errors++; $display("FAIL rnd_alloc_ready c%0d: got %0b expected %0b", c, alloc_ready, m_alloc_ready()); end
      cyc();
      checks++; if (ROBEN !== e_roben || opcode !== e_opc || is_beq !== e_beq || is_bne !== e_bne) begin
        errors++; $display("FAIL rnd_issue c%0d: got rob %0h opc %0h beq %0b bne %0b expected %0h %0h %0b %0b", c, ROBEN, opcode, is_beq, is_bne, e_roben, e_opc, e_beq, e_bne);
      end
      if (!e_bubble) begin
        checks++; if (A !== e_a || B !== e_b || ALUOP !== e_aluop) begin errors++; $display("FAIL rnd_operands c%0d: got %0h %0h %0h expected %0h %0h %0h", c, A, B, ALUOP, e_a, e_b, e_aluop); end
      end
      checks++; if (count !== CW'(m_count)) begin errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, m_count); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 16 (1 << `BUFFER_SIZE_bitsRS), number of reservation entries.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports alloc_valid input 1 and alloc_ready output 1, the allocation handshake.
REQ-005 SHALL have alloc inputs: alloc_ROBEN [`ROB_SIZE_bits:0], alloc_opcode [11:0], alloc_ALUOP [3:0], alloc_is_beq 1, alloc_is_bne 1.
REQ-006 SHALL have alloc operand inputs: alloc_Vj [31:0], alloc_Qj [`ROB_SIZE_bits:0], alloc_Vk [31:0], alloc_Qk [`ROB_SIZE_bits:0]; a tag of 0 means the value is present.
REQ-007 SHALL have CDB inputs: cdb_valid 1, cdb_ROBEN [`ROB_SIZE_bits:0], cdb_res [31:0].
REQ-008 SHALL have input flush 1, a mispredict squash.
REQ-009 SHALL have registered ALU-facing outputs: ROBEN [`ROB_SIZE_bits:0], opcode [11:0], ALUOP [3:0], is_beq 1, is_bne 1, A [31:0], B [31:0].
REQ-010 SHALL have output count [`BUFFER_SIZE_bitsRS:0], the number of occupied entries.

Function
REQ-011 Each entry SHALL be in one of FREE, WAIT (some tag nonzero) or READY (Qj==0 and Qk==0).
REQ-012 alloc_ready SHALL be combinational and high iff at least one entry is FREE and flush is low.
REQ-013 On a posedge with alloc_valid and alloc_ready high, the lowest-index FREE entry SHALL take all alloc fields.
REQ-014 Allocation bypass: if cdb_valid is high and cdb_ROBEN equals a nonzero alloc_Qj or alloc_Qk, the entry SHALL store cdb_res and a tag of 0 for that operand.
REQ-015 Snoop: every posedge with cdb_valid high, each WAIT entry whose Qj or Qk equals a nonzero cdb_ROBEN SHALL capture cdb_res and clear that tag.
REQ-016 Issue: each posedge, the lowest-index READY entry SHALL drive ROBEN/opcode/ALUOP/is_beq/is_bne/A=Vj/B=Vk and become FREE.
REQ-017 If no entry is READY, outputs SHALL carry ROBEN=0, opcode=0, is_beq=0 and is_bne=0; ROBEN=0 marks a bubble.
REQ-018 Issue rate SHALL be at most one per cycle; the ALU is always free and samples on the following negedge.
REQ-019 Latency: an entry allocated with both tags 0 at edge N SHALL issue no earlier than edge N+1.
REQ-020 An operand woken by the CDB at edge N SHALL make its entry eligible at edge N+1, not N.
REQ-021 When full, an entry freed by issue at edge N SHALL be allocatable from edge N+1; alloc_ready reflects only current occupancy.
REQ-022 flush high at a posedge SHALL free all entries, ignore alloc and CDB that cycle, and force a bubble on the outputs.
REQ-023 count SHALL update each posedge by (+1 on alloc) (-1 on issue), and reset to 0 on flush.
REQ-024 A CDB tag that matches no entry SHALL have no effect.

Reset
REQ-025 While rst is low, all entries SHALL be FREE, count=0 and every output 0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard all entries; the first allocation is accepted on the first posedge after rst rises.

Structure
REQ-027 The shared header/package SHALL hold ROB_SIZE_bits, BUFFER_SIZE_bitsRS, the ALUOP encodings and the opcodes; no local redefinitions.
REQ-028 One sub-module rs_select SHALL exist: a parameterised lowest-index priority encoder, used for both the free-slot search and the ready-entry search.

Verification
REQ-029 Ready alloc (ROBEN=3, ALUOP=0000, Vj=5, Vk=7, Qj=Qk=0) -> next posedge: ROBEN=3, A=5, B=7; ALU FU_res=12 at the following negedge.
REQ-030 Alloc with Qj=4; CDB ROBEN=4, res=0x10 two cycles later -> issue one edge after the CDB, with A=0x10.
REQ-031 Allocation bypass: alloc Qk=6 in the same cycle as CDB ROBEN=6, res=9 -> stored B=9, issues next edge.
REQ-032 Fill 16 entries, all waiting -> alloc_ready=0 and count=16; one wakes -> it issues, and alloc_ready=1 in the next cycle.
REQ-033 Flush with 5 entries occupied -> count=0, ROBEN=0 next edge, and a later CDB causes no issue.
REQ-034 rst low mid-run with 3 entries pending -> all outputs 0 immediately; no stale issue after release.
